// File: rtl/apb_uart_pkg.sv
// apb_uart_pkg: shared UART receiver state type, oversample constant and vote helper
package apb_uart_pkg;
  localparam int UART_OVERSAMPLE = 8;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_rx_state_e;
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction
endpackage

// File: rtl/dual_flop_sync.sv
// dual_flop_sync: two-flop synchroniser for an asynchronous input with configurable reset value
module dual_flop_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic arst_i,
  input  logic d,
  output logic q
);
  logic m;
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) {q, m} <= {2{RST_VAL}};
    else {q, m} <= {m, d};
  end
endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampled UART receiver with 3-sample majority vote and a valid/ready byte port
module uart_rx
  import apb_uart_pkg::*;
#(
  parameter int OVERSAMPLE = UART_OVERSAMPLE,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk_i,
  input  logic                 arst_i,
  input  logic                 rx_i,
  input  logic                 parity_en_i,
  input  logic                 extra_stop_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 data_valid_o,
  input  logic                 data_ready_i,
  output logic                 parity_error_o,
  output logic                 frame_error_o,
  output logic                 overrun_o
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] T_S3 = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_S4 = TW'(OVERSAMPLE / 2);
  localparam logic [TW-1:0] T_V = TW'(OVERSAMPLE / 2 + 1);
  localparam logic [TW-1:0] T_END = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);
  uart_rx_state_e state;
  logic rx_s;
  logic [TW-1:0] tick;
  logic [BW-1:0] bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic s3, s4, vbit, par_en, two_stop, stop_idx, perr, ferr;
  logic vote, at_v, at_end, issue;
  dual_flop_sync #(.RST_VAL(1'b1)) u_sync (
    .clk_i (clk_i),
    .arst_i(arst_i),
    .d     (rx_i),
    .q     (rx_s)
  );
  always_comb begin
    vote = maj3(s3, s4, rx_s);
    at_v = tick == T_V;
    at_end = tick == T_END;
    issue = state == STOP && at_v && stop_idx == two_stop;
  end
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state <= IDLE;
      tick <= '0;
      bit_idx <= '0;
      shreg <= '0;
      s3 <= 1'b1;
      s4 <= 1'b1;
      vbit <= 1'b1;
      par_en <= 1'b0;
      two_stop <= 1'b0;
      stop_idx <= 1'b0;
      perr <= 1'b0;
      ferr <= 1'b0;
      data_o <= '0;
      data_valid_o <= 1'b0;
      parity_error_o <= 1'b0;
      frame_error_o <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      tick <= tick + 1'b1;
      if (tick == T_S3) s3 <= rx_s;
      if (tick == T_S4) s4 <= rx_s;
      if (at_v) vbit <= vote;
      overrun_o <= 1'b0;
      if (data_valid_o && data_ready_i) data_valid_o <= 1'b0;
      case (state)
        IDLE: if (!rx_s) begin
          state <= START;
          tick <= '0;
          par_en <= parity_en_i;
          two_stop <= extra_stop_i;
          stop_idx <= 1'b0;
          perr <= 1'b0;
          ferr <= 1'b0;
        end
        START: if (at_end) begin
          state <= vbit ? IDLE : DATA;
          bit_idx <= '0;
        end
        DATA: begin
          if (at_v) shreg[bit_idx] <= vote;
          if (at_end) begin
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == B_LAST) state <= par_en ? PARITY : STOP;
          end
        end
        PARITY: begin
          if (at_v) perr <= vote ^ (^shreg);
          if (at_end) state <= STOP;
        end
        STOP: begin
          if (at_v) ferr <= ferr | ~vote;
          if (at_end) stop_idx <= 1'b1;
          if (issue) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (issue) begin
        if (!data_valid_o || data_ready_i) begin
          data_o <= shreg;
          parity_error_o <= perr;
          frame_error_o <= ferr | ~vote;
          data_valid_o <= 1'b1;
        end else overrun_o <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames with a scoreboard queue popped by a negedge monitor on each handshake
module tb_uart_rx;
  typedef struct packed {
    logic [7:0]  data;
    logic        perr;
    logic        ferr;
    logic [31:0] t_valid;
  } exp_t;
  logic clk_i = 1'b0, arst_i = 1'b1, rx_i = 1'b1;
  logic parity_en_i = 1'b0, extra_stop_i = 1'b0, data_ready_i = 1'b1;
  logic [7:0] data_o;
  logic data_valid_o, parity_error_o, frame_error_o, overrun_o;
  exp_t sb[$];
  int checks = 0, passed = 0, n_ovr = 0, n_rise = 0, r;
  logic prev_valid = 1'b0;

  uart_rx dut (
    .clk_i         (clk_i),
    .arst_i        (arst_i),
    .rx_i          (rx_i),
    .parity_en_i   (parity_en_i),
    .extra_stop_i  (extra_stop_i),
    .data_o        (data_o),
    .data_valid_o  (data_valid_o),
    .data_ready_i  (data_ready_i),
    .parity_error_o(parity_error_o),
    .frame_error_o (frame_error_o),
    .overrun_o     (overrun_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [15:0] frame(input logic [7:0] d, input logic par, input logic pbit,
                                        input logic two, input logic stop);
    logic [15:0] f;
    int s;
    f = '1;
    f[0] = 1'b0;
    f[8:1] = d;
    if (par) f[9] = pbit;
    s = par ? 10 : 9;
    f[s] = stop;
    if (two) f[s+1] = stop;
    return f;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #2;
    end
  endtask

  task automatic send(input logic [15:0] f, input int n, input bit noise);
    for (int b = 0; b < n; b++)
      for (int j = 0; j < 8; j++) begin
        rx_i = (noise && j == 5) ? ~f[b] : f[b];
        @(posedge clk_i);
        #2;
      end
    rx_i = 1'b1;
  endtask

  // called at posedge+2, just before the start bit is driven; lat is the edge after which valid rises
  task automatic expect_byte(input logic [7:0] d, input logic pe, input logic fe, input int lat);
    exp_t e;
    e.data = d;
    e.perr = pe;
    e.ferr = fe;
    e.t_valid = lat != 0 ? 32'($time) + 32'(13 + 10 * lat) : 32'd0;
    sb.push_back(e);
  endtask

  always @(negedge clk_i) begin
    exp_t e;
    if (!arst_i) begin
      if (overrun_o) n_ovr++;
      if (data_valid_o && !prev_valid) begin
        n_rise++;
        if (sb.size() == 0) check("unexpected_valid", 32'(sb.size()), 32'd1);
        else if (sb[0].t_valid != 0) check("latency", 32'($time), sb[0].t_valid);
      end
      if (data_valid_o && data_ready_i) begin
        if (sb.size() == 0) check("unexpected_byte", 32'(sb.size()), 32'd1);
        else begin
          e = sb.pop_front();
          check("data", 32'(data_o), 32'(e.data));
          check("parity_error", 32'(parity_error_o), 32'(e.perr));
          check("frame_error", 32'(frame_error_o), 32'(e.ferr));
        end
      end
    end
    prev_valid = data_valid_o;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    idle(3);
    check("rst_data", 32'(data_o), 32'd0);
    check("rst_valid", 32'(data_valid_o), 32'd0);
    check("rst_perr", 32'(parity_error_o), 32'd0);
    check("rst_ferr", 32'(frame_error_o), 32'd0);
    check("rst_overrun", 32'(overrun_o), 32'd0);
    arst_i = 1'b0;
    idle(4);
    expect_byte(8'h55, 1'b0, 1'b0, 80);
    send(frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1), 10, 1'b0);
    idle(24);
    parity_en_i = 1'b1;
    expect_byte(8'hA3, 1'b0, 1'b0, 88);
    send(frame(8'hA3, 1'b1, 1'b0, 1'b0, 1'b1), 11, 1'b0);
    idle(24);
    expect_byte(8'hA3, 1'b1, 1'b0, 88);
    send(frame(8'hA3, 1'b1, 1'b1, 1'b0, 1'b1), 11, 1'b0);
    idle(24);
    parity_en_i = 1'b0;
    r = n_rise;
    rx_i = 1'b0;
    idle(3);
    rx_i = 1'b1;
    idle(24);
    check("glitch_no_valid", 32'(n_rise), 32'(r));
    expect_byte(8'h0F, 1'b0, 1'b1, 80);
    send(frame(8'h0F, 1'b0, 1'b0, 1'b0, 1'b0), 10, 1'b0);
    idle(32);
    data_ready_i = 1'b0;
    r = n_ovr;
    expect_byte(8'h11, 1'b0, 1'b0, 80);
    send(frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b1), 10, 1'b0);
    check("no_early_overrun", 32'(n_ovr - r), 32'd0);
    send(frame(8'h22, 1'b0, 1'b0, 1'b0, 1'b1), 10, 1'b0);
    idle(8);
    check("overrun_pulses", 32'(n_ovr - r), 32'd1);
    check("held_data", 32'(data_o), 32'h11);
    check("held_valid", 32'(data_valid_o), 32'd1);
    data_ready_i = 1'b1;
    idle(2);
    check("valid_cleared", 32'(data_valid_o), 32'd0);
    idle(16);
    extra_stop_i = 1'b1;
    expect_byte(8'hC4, 1'b0, 1'b0, 88);
    send(frame(8'hC4, 1'b0, 1'b0, 1'b1, 1'b1), 11, 1'b1);
    idle(24);
    extra_stop_i = 1'b0;
    send(frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1), 5, 1'b0);
    arst_i = 1'b1;
    idle(2);
    check("mid_rst_data", 32'(data_o), 32'd0);
    check("mid_rst_valid", 32'(data_valid_o), 32'd0);
    check("mid_rst_perr", 32'(parity_error_o), 32'd0);
    check("mid_rst_ferr", 32'(frame_error_o), 32'd0);
    check("mid_rst_overrun", 32'(overrun_o), 32'd0);
    arst_i = 1'b0;
    idle(16);
    expect_byte(8'h3C, 1'b0, 1'b0, 80);
    send(frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1), 10, 1'b0);
    idle(24);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
